// File: rtl/bcd_down_timer_if.sv
// rtl/bcd_down_timer_if.sv - control/status bundle for the BCD countdown timer
interface bcd_down_timer_if;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [7:0] out;
  logic       tick;
  logic       busy;
  logic       done;

  // controller side: issues commands, observes count and status
  modport master (
    output load, load_val, start, pause,
    input  out, tick, busy, done
  );

  // timer side
  modport slave (
    input  load, load_val, start, pause,
    output out, tick, busy, done
  );
endinterface

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - loadable two-digit BCD countdown timer with prescaler (option: BCD_DOWN_TIMER_AUTO_RELOAD_EN)
module bcd_down_timer #(
  parameter int DIV   = 500,
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  bcd_down_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [7:0]       count, count_nxt;
  logic [7:0]       reload, reload_nxt;
  logic             tick_q, tick_nxt;
  logic             done_q, done_nxt;
  logic             busy_q, busy_nxt;
  logic [7:0]       dec_val;

  // Clamp each nibble of a preset into the 0..9 BCD range.
  function automatic logic [7:0] sanitize(input logic [7:0] v);
    logic [3:0] t, o;
    t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, o};
  endfunction

  // One BCD decrement; the caller never applies it to 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign dec_val = bcd_dec(count);

  // Next-state, prescaler and count update for the four-state controller.
  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    count_nxt  = count;
    reload_nxt = reload;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE, DONE: begin
        presc_nxt = '0;
        if (bus.load) begin
          count_nxt  = sanitize(bus.load_val);
          reload_nxt = sanitize(bus.load_val);
        end else if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == 8'h00) begin
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
          // Cycle after reaching 00: restart from the preset, prescaler keeps running.
          if (reload != 8'h00) begin
            count_nxt = reload;
            presc_nxt = presc + 1'b1;
            if (bus.pause)
              state_nxt = PAUSE;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            presc_nxt = '0;
          end
`else
          // Started with nothing to count: finish immediately, without a tick.
          state_nxt = DONE;
          done_nxt  = 1'b1;
          presc_nxt = '0;
`endif
        end else begin
          if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            count_nxt = dec_val;
            if (dec_val == 8'h00) begin
              done_nxt = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
              if (reload == 8'h00)
                state_nxt = DONE;
`else
              state_nxt = DONE;
`endif
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
          // Pause lands after this cycle's update, so a due tick is never lost.
          if (bus.pause && state_nxt == RUN)
            state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.load) begin
          count_nxt  = sanitize(bus.load_val);
          reload_nxt = sanitize(bus.load_val);
        end else if (bus.start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      count  <= 8'h00;
      reload <= 8'h00;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      tick_q <= tick_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign bus.out  = count;
  assign bus.tick = tick_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule
